// File: rtl/pkt_word_tracker_pkg.sv
// Shared definitions for the packet word tracker: FSM state encodings and the
// helper that builds the CPU-port mask for the tuser source-port field.
package pkt_track_pkg;

  // Nonzero one-hot style encodings make the state easy to spot on a debug bus.
  typedef enum logic [2:0] {
    S_START = 3'd4,
    S_HDR   = 3'd2,
    S_DATA  = 3'd1
  } state_e;

  localparam int MAX_PORT_BITS = 64;

  // Port bits alternate MAC/CPU, so every odd bit of the field is a CPU port.
  function automatic logic [MAX_PORT_BITS-1:0] cpu_port_mask(input int num_ports);
    logic [MAX_PORT_BITS-1:0] mask;
    mask = '0;
    for (int j = 1; j < MAX_PORT_BITS; j += 2) begin
      if (j < 2 * num_ports) mask[j] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/pkt_word_tracker_if.sv
// Stream-side bundle for the packet word tracker: AXI-Stream qualifiers in,
// per-beat strobes and per-packet summary out.
interface pkt_word_tracker_if #(
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_HDR_WORDS          = 4,
  parameter int C_IDX_WIDTH          = 8,
  parameter int C_NUM_PORTS          = 4,
  parameter int C_PKT_CNT_WIDTH      = 32
);

  logic [C_S_AXIS_TUSER_WIDTH-1:0] i_tuser;
  logic                            i_tvalid;
  logic                            i_tready;
  logic                            i_tlast;

  logic [C_HDR_WORDS-1:0]          o_hdr_word;
  logic [C_IDX_WIDTH-1:0]          o_word_idx;
  logic                            o_sop;
  logic                            o_eop;
  logic [2*C_NUM_PORTS-1:0]        o_src_port;
  logic                            o_pkt_is_from_cpu;
  logic                            o_pkt_done;
  logic [C_IDX_WIDTH-1:0]          o_pkt_len;
  logic                            o_pkt_runt;
  logic [C_PKT_CNT_WIDTH-1:0]      o_pkt_cnt;

  modport slave (
    input  i_tuser, i_tvalid, i_tready, i_tlast,
    output o_hdr_word, o_word_idx, o_sop, o_eop, o_src_port,
           o_pkt_is_from_cpu, o_pkt_done, o_pkt_len, o_pkt_runt, o_pkt_cnt
  );

  modport master (
    output i_tuser, i_tvalid, i_tready, i_tlast,
    input  o_hdr_word, o_word_idx, o_sop, o_eop, o_src_port,
           o_pkt_is_from_cpu, o_pkt_done, o_pkt_len, o_pkt_runt, o_pkt_cnt
  );

endinterface

// File: rtl/pkt_word_tracker_src_decode.sv
// Source-port decode: slices the port field out of tuser and flags packets
// that arrived on any CPU port.
module pkt_src_decode
  import pkt_track_pkg::*;
#(
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_PORTS          = 4,
  parameter int C_SRC_PORT_OFF       = 16
) (
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_i,
  output logic [2*C_NUM_PORTS-1:0]        src_port_o,
  output logic                            from_cpu_o
);

  localparam int PW = 2 * C_NUM_PORTS;
  localparam logic [MAX_PORT_BITS-1:0] CPU_MASK_ALL = cpu_port_mask(C_NUM_PORTS);
  localparam logic [PW-1:0]            CPU_MASK     = CPU_MASK_ALL[PW-1:0];

  logic unused_tuser;

  // Multiple set bits pass through untouched; from_cpu is simply their OR.
  assign src_port_o   = tuser_i[C_SRC_PORT_OFF +: PW];
  assign from_cpu_o   = |(src_port_o & CPU_MASK);
  assign unused_tuser = ^tuser_i;

endmodule

// File: rtl/pkt_word_tracker.sv
// Tracks AXI-Stream beats per packet: one-hot header-word strobes, word index,
// latched source port, and registered per-packet length/runt/count summary.
module pkt_word_tracker
  import pkt_track_pkg::*;
#(
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_HDR_WORDS          = 4,
  parameter int C_IDX_WIDTH          = 8,
  parameter int C_NUM_PORTS          = 4,
  parameter int C_SRC_PORT_OFF       = 16,
  parameter int C_PKT_CNT_WIDTH      = 32
) (
  input logic                clk,
  input logic                resetn,
  pkt_word_tracker_if.slave  bus
);

  localparam int                     PW      = 2 * C_NUM_PORTS;
  localparam logic [C_IDX_WIDTH-1:0] IDX_MAX = '1;
  localparam logic [C_IDX_WIDTH-1:0] IDX_ONE = C_IDX_WIDTH'(1);

  state_e                     state_q, state_d;
  logic [C_IDX_WIDTH-1:0]     idx_q, idx_d;
  logic [PW-1:0]              src_q, src_d;
  logic                       cpu_q, cpu_d;
  logic                       done_q;
  logic [C_IDX_WIDTH-1:0]     len_q, len_d;
  logic                       runt_q, runt_d;
  logic [C_PKT_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                   beat;
  logic                   sop;
  logic                   eop;
  logic [C_HDR_WORDS-1:0] hdr_word;
  logic [C_IDX_WIDTH-1:0] idx_inc;
  logic                   hdr_last;
  logic                   runt_now;
  logic [PW-1:0]          dec_src;
  logic                   dec_cpu;

  pkt_src_decode #(
    .C_S_AXIS_TUSER_WIDTH (C_S_AXIS_TUSER_WIDTH),
    .C_NUM_PORTS          (C_NUM_PORTS),
    .C_SRC_PORT_OFF       (C_SRC_PORT_OFF)
  ) u_src_decode (
    .tuser_i    (bus.i_tuser),
    .src_port_o (dec_src),
    .from_cpu_o (dec_cpu)
  );

  // Gating with resetn keeps every combinational strobe at 0 while in reset.
  assign beat     = bus.i_tvalid & bus.i_tready & resetn;
  assign idx_inc  = (idx_q == IDX_MAX) ? idx_q : idx_q + IDX_ONE;
  assign hdr_last = (32'(idx_q) == C_HDR_WORDS - 1);
  assign runt_now = (32'(idx_q) + 32'd1) < 32'(C_HDR_WORDS);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_START;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START: if (beat && !bus.i_tlast) state_d = S_HDR;
      S_HDR: begin
        if (beat) begin
          if (bus.i_tlast)   state_d = S_START;
          else if (hdr_last) state_d = S_DATA;
        end
      end
      S_DATA:  if (beat && bus.i_tlast) state_d = S_START;
      default: state_d = S_START;
    endcase
  end

  always_comb begin
    sop      = beat && (state_q == S_START);
    eop      = beat && bus.i_tlast;
    hdr_word = '0;
    for (int k = 0; k < C_HDR_WORDS; k++) begin
      hdr_word[k] = beat && (32'(idx_q) == k);
    end
  end

  // Index saturates rather than wrapping; the eop beat restarts it at 0.
  always_comb begin
    idx_d  = idx_q;
    src_d  = src_q;
    cpu_d  = cpu_q;
    len_d  = len_q;
    runt_d = runt_q;
    cnt_d  = cnt_q;
    if (beat) idx_d = eop ? '0 : idx_inc;
    if (sop) begin
      src_d = dec_src;
      cpu_d = dec_cpu;
    end
    if (eop) begin
      len_d  = idx_inc;
      runt_d = runt_now;
      cnt_d  = cnt_q + C_PKT_CNT_WIDTH'(1);
    end
  end

  // NOTE: all registers here are plain flops, so all are cleared by reset;
  // an abandoned packet leaves nothing behind and raises no done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q  <= '0;
      src_q  <= '0;
      cpu_q  <= 1'b0;
      done_q <= 1'b0;
      len_q  <= '0;
      runt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      src_q  <= src_d;
      cpu_q  <= cpu_d;
      done_q <= eop;
      len_q  <= len_d;
      runt_q <= runt_d;
      cnt_q  <= cnt_d;
    end
  end

  // On the sop beat the decode is forwarded directly; later beats use the latch.
  assign bus.o_hdr_word        = hdr_word;
  assign bus.o_word_idx        = idx_q;
  assign bus.o_sop             = sop;
  assign bus.o_eop             = eop;
  assign bus.o_src_port        = sop ? dec_src : src_q;
  assign bus.o_pkt_is_from_cpu = sop ? dec_cpu : cpu_q;
  assign bus.o_pkt_done        = done_q;
  assign bus.o_pkt_len         = len_q;
  assign bus.o_pkt_runt        = runt_q;
  assign bus.o_pkt_cnt         = cnt_q;

endmodule

// File: tb/tb_pkt_word_tracker.sv
// Scoreboard bench for pkt_word_tracker: the driver queues expected per-beat
// and per-packet responses, a negedge monitor pops and compares them.
module tb_pkt_word_tracker;

  localparam int TW      = 128;
  localparam int HW      = 4;
  localparam int IW      = 3;
  localparam int NP      = 4;
  localparam int OFF     = 16;
  localparam int CW      = 32;
  localparam int IDX_MAX = (1 << IW) - 1;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  pkt_word_tracker_if #(
    .C_S_AXIS_TUSER_WIDTH (TW),
    .C_HDR_WORDS          (HW),
    .C_IDX_WIDTH          (IW),
    .C_NUM_PORTS          (NP),
    .C_PKT_CNT_WIDTH      (CW)
  ) bus ();

  pkt_word_tracker #(
    .C_S_AXIS_TUSER_WIDTH (TW),
    .C_HDR_WORDS          (HW),
    .C_IDX_WIDTH          (IW),
    .C_NUM_PORTS          (NP),
    .C_SRC_PORT_OFF       (OFF),
    .C_PKT_CNT_WIDTH      (CW)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct packed {
    logic [HW-1:0]   hdr;
    logic [IW-1:0]   idx;
    logic            sop;
    logic            eop;
    logic [2*NP-1:0] src;
    logic            cpu;
  } beat_t;

  typedef struct packed {
    logic [IW-1:0] len;
    logic          runt;
    logic [CW-1:0] cnt;
  } sum_t;

  beat_t beat_q[$];
  sum_t  sum_q[$];
  int    n_checks  = 0;
  int    n_err     = 0;
  int    model_cnt = 0;
  logic  prev_eop  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A packet is from a CPU when any odd-numbered port bit is set.
  function automatic logic is_cpu(input logic [2*NP-1:0] s);
    for (int j = 1; j < 2 * NP; j += 2) begin
      if (s[j]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic idle(input int n);
    bus.i_tvalid = 1'b0;
    bus.i_tready = 1'($urandom);
    bus.i_tlast  = 1'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // stall_at: hold tready low for 2 cycles before that beat.
  // abort_at: assert reset in place of that beat, abandoning the packet.
  task automatic send_pkt(input int len, input logic [7:0] src, input bit rnd,
                          input int stall_at, input int abort_at);
    logic [TW-1:0] tu;
    for (int k = 0; k < len; k++) begin
      beat_t e;
      int    tries;
      bit    v;
      bit    r;
      tu = {$urandom, $urandom, $urandom, $urandom};
      if (k == 0) tu[OFF +: 2*NP] = src;
      if (k == abort_at) begin
        bus.i_tuser  = tu;
        bus.i_tvalid = 1'b1;
        bus.i_tready = 1'b1;
        bus.i_tlast  = 1'b0;
        resetn       = 1'b0;
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        resetn       = 1'b1;
        bus.i_tvalid = 1'b0;
        model_cnt    = 0;
        return;
      end
      e.hdr = (k < HW) ? HW'(1 << k) : '0;
      e.idx = (k > IDX_MAX) ? IW'(IDX_MAX) : IW'(k);
      e.sop = (k == 0);
      e.eop = (k == len - 1);
      e.src = src;
      e.cpu = is_cpu(src);
      beat_q.push_back(e);
      if (k == len - 1) begin
        sum_t s;
        model_cnt++;
        s.len  = (len > IDX_MAX) ? IW'(IDX_MAX) : IW'(len);
        s.runt = (len < HW);
        s.cnt  = CW'(model_cnt);
        sum_q.push_back(s);
      end
      tries = 0;
      do begin
        v = !rnd || ($urandom_range(0, 3) != 0) || (tries > 20);
        r = !rnd || ($urandom_range(0, 3) != 0) || (tries > 20);
        if (k == stall_at && tries < 2) begin
          v = 1'b1;
          r = 1'b0;
        end
        bus.i_tvalid = v;
        bus.i_tready = r;
        bus.i_tuser  = tu;
        bus.i_tlast  = (k == len - 1);
        @(posedge clk);
        #1;
        tries++;
      end while (!(v && r));
    end
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      check("reset_outputs",
            64'({bus.o_hdr_word, bus.o_word_idx, bus.o_sop, bus.o_eop, bus.o_src_port,
                 bus.o_pkt_is_from_cpu, bus.o_pkt_done, bus.o_pkt_len, bus.o_pkt_runt,
                 bus.o_pkt_cnt}), 64'd0);
      prev_eop = 1'b0;
    end else begin
      check("pkt_done", 64'(bus.o_pkt_done), 64'(prev_eop));
      if (bus.o_pkt_done && sum_q.size() > 0) begin
        sum_t s;
        s = sum_q.pop_front();
        check("pkt_len",  64'(bus.o_pkt_len),  64'(s.len));
        check("pkt_runt", 64'(bus.o_pkt_runt), 64'(s.runt));
        check("pkt_cnt",  64'(bus.o_pkt_cnt),  64'(s.cnt));
      end
      if (bus.i_tvalid && bus.i_tready && beat_q.size() > 0) begin
        beat_t e;
        e = beat_q.pop_front();
        check("hdr_word", 64'(bus.o_hdr_word),        64'(e.hdr));
        check("word_idx", 64'(bus.o_word_idx),        64'(e.idx));
        check("sop",      64'(bus.o_sop),             64'(e.sop));
        check("eop",      64'(bus.o_eop),             64'(e.eop));
        check("src_port", 64'(bus.o_src_port),        64'(e.src));
        check("from_cpu", 64'(bus.o_pkt_is_from_cpu), 64'(e.cpu));
        prev_eop = e.eop;
      end else begin
        check("idle_strobes", 64'({bus.o_hdr_word, bus.o_sop, bus.o_eop}), 64'd0);
        check("idle_idx", 64'(bus.o_word_idx),
              (beat_q.size() > 0) ? 64'(beat_q[0].idx) : 64'd0);
        prev_eop = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_tuser  = '0;
    bus.i_tvalid = 1'b0;
    bus.i_tready = 1'b0;
    bus.i_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(2);

    send_pkt(1,  8'h02, 1'b0, -1, -1); idle(2);
    send_pkt(6,  8'h01, 1'b0, -1, -1); idle(2);
    send_pkt(3,  8'h08, 1'b0,  1, -1); idle(2);
    send_pkt(4,  8'h20, 1'b0, -1, -1); idle(2);
    send_pkt(3,  8'h80, 1'b0, -1, -1);
    send_pkt(2,  8'h04, 1'b0, -1, -1);
    send_pkt(1,  8'h40, 1'b0, -1, -1);
    send_pkt(1,  8'h03, 1'b0, -1, -1); idle(2);
    send_pkt(12, 8'h10, 1'b0, -1, -1); idle(3);
    send_pkt(5,  8'h20, 1'b0, -1,  2);
    send_pkt(2,  8'h01, 1'b0, -1, -1); idle(2);

    for (int p = 0; p < 30; p++) begin
      send_pkt($urandom_range(1, 12), 8'($urandom_range(0, 255)), 1'b1, -1, -1);
      idle($urandom_range(0, 2));
    end
    idle(5);

    check("beat_queue_drained", 64'(beat_q.size()), 64'd0);
    check("sum_queue_drained",  64'(sum_q.size()),  64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
